// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings and constants for the binary-guess round controller
// Contents: round state encodings, BCD digit width, BCD_NINE, default round digits (60 s).
package game_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_NINE       = 4'd9;
    localparam logic [BCD_W-1:0] DEF_ROUND_TENS = 4'd6;
    localparam logic [BCD_W-1:0] DEF_ROUND_ONES = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_PLAY = 2'b10,
        ST_OVER = 2'b11
    } state_t;

endpackage

// File: rtl/game_round_ctrl_if.sv
// rtl/game_round_ctrl_if.sv - target request/response handshake between round controller and target generator
// Signals:
//   target          generator -> controller, current target value
//   target_valid    generator -> controller, high while target is stable
//   new_target_req  controller -> generator, one-clk request for a fresh target
// Modports: master = round controller, slave = target generator.
interface game_round_ctrl_if #(
    parameter int GUESS_W = 8
);
    logic [GUESS_W-1:0] target;
    logic               target_valid;
    logic               new_target_req;

    modport master (
        input  target,
        input  target_valid,
        output new_target_req
    );

    modport slave (
        output target,
        output target_valid,
        input  new_target_req
    );
endinterface

// File: rtl/bcd2_countdown.sv
// rtl/bcd2_countdown.sv - two-digit BCD down-counter with load, dec-by-1 and dec-by-N, floored at 00
// Ports:
//   clk, reset            clock, asynchronous active-high reset (loads INIT_TENS:INIT_ONES)
//   load, load_tens/ones  synchronous load of a new BCD value (has priority over decrement)
//   dec1                  subtract 1 this edge
//   decn_en, decn         additionally subtract decn this edge
//   tens, ones            registered BCD count
//   zero_next             the decremented value is 00 (valid whenever load is low)
module bcd2_countdown
    import game_pkg::*;
#(
    parameter logic [BCD_W-1:0] INIT_TENS = DEF_ROUND_TENS,
    parameter logic [BCD_W-1:0] INIT_ONES = DEF_ROUND_ONES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_tens,
    input  logic [BCD_W-1:0] load_ones,
    input  logic             dec1,
    input  logic             decn_en,
    input  logic [BCD_W-1:0] decn,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             zero_next
);

    logic [6:0]       cur_bin;
    logic [6:0]       sub_amt;
    logic [6:0]       next_bin;
    logic [BCD_W-1:0] next_tens;
    logic [BCD_W-1:0] next_ones;

    // Work in binary so a combined tick+penalty deduction borrows across digits
    // correctly and floors cleanly at zero, then split back into BCD digits.
    always_comb begin
        cur_bin  = 7'(tens) * 7'd10 + 7'(ones);
        sub_amt  = {6'd0, dec1} + (decn_en ? {3'd0, decn} : 7'd0);
        next_bin = (cur_bin > sub_amt) ? (cur_bin - sub_amt) : 7'd0;
        next_tens = 4'(next_bin / 7'd10);
        next_ones = 4'(next_bin % 7'd10);
        zero_next = (next_bin == 7'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens <= INIT_TENS;
            ones <= INIT_ONES;
        end else if (load) begin
            tens <= load_tens;
            ones <= load_ones;
        end else if (dec1 || decn_en) begin
            tens <= next_tens;
            ones <= next_ones;
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round sequencer for the binary-guess game: countdown, target requests, judging, BCD score
// Optional build macro: PENALTY_EN (a miss also deducts PENALTY_SECS from the countdown).
// Ports:
//   clk, reset                  system clock, asynchronous active-high reset
//   tick_1hz                    one-clk enable once per second
//   start_key_n, submit_key_n   raw active-low buttons (synchronized here)
//   guess                       player guess
//   tgt                         target handshake (master side)
//   secs_tens, secs_ones        BCD remaining time
//   score_tens, score_ones      BCD score
//   state_o                     IDLE=00 LOAD=01 PLAY=10 OVER=11
//   hit_led, miss_led           result of the last judged submit
module game_round_ctrl
    import game_pkg::*;
#(
    parameter logic [BCD_W-1:0] ROUND_TENS   = DEF_ROUND_TENS,
    parameter logic [BCD_W-1:0] ROUND_ONES   = DEF_ROUND_ONES,
    parameter int               GUESS_W      = 8,
    parameter logic [BCD_W-1:0] PENALTY_SECS = 4'd5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_1hz,
    input  logic               start_key_n,
    input  logic               submit_key_n,
    input  logic [GUESS_W-1:0] guess,
    game_round_ctrl_if.master  tgt,
    output logic [BCD_W-1:0]   secs_tens,
    output logic [BCD_W-1:0]   secs_ones,
    output logic [BCD_W-1:0]   score_tens,
    output logic [BCD_W-1:0]   score_ones,
    output logic [1:0]         state_o,
    output logic               hit_led,
    output logic               miss_led
);

    state_t           state;
    logic             ntr_q;
    logic [2:0]       start_sync;
    logic [2:0]       submit_sync;
    logic             start_p;
    logic             submit_p;
    logic             is_hit;
    logic             cnt_load;
    logic             cnt_dec1;
    logic             cnt_decn_en;
    logic             cnt_zero_next;
    logic [BCD_W-1:0] score_tens_inc;
    logic [BCD_W-1:0] score_ones_inc;

    // [0],[1] are the metastability pair, [2] is the previous synchronized
    // level; a 1->0 transition of [1] makes a single press pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_sync  <= 3'b111;
            submit_sync <= 3'b111;
        end else begin
            start_sync  <= {start_sync[1:0], start_key_n};
            submit_sync <= {submit_sync[1:0], submit_key_n};
        end
    end

    assign start_p  = start_sync[2] & ~start_sync[1];
    assign submit_p = submit_sync[2] & ~submit_sync[1];
    assign is_hit   = (guess == tgt.target);

    assign cnt_load = start_p && ((state == ST_IDLE) || (state == ST_OVER));
    assign cnt_dec1 = (state == ST_PLAY) && tick_1hz;
`ifdef PENALTY_EN
    assign cnt_decn_en = (state == ST_PLAY) && submit_p && !is_hit;
`else
    assign cnt_decn_en = 1'b0;
`endif

    bcd2_countdown #(
        .INIT_TENS (ROUND_TENS),
        .INIT_ONES (ROUND_ONES)
    ) u_round_time (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_tens (ROUND_TENS),
        .load_ones (ROUND_ONES),
        .dec1      (cnt_dec1),
        .decn_en   (cnt_decn_en),
        .decn      (PENALTY_SECS),
        .tens      (secs_tens),
        .ones      (secs_ones),
        .zero_next (cnt_zero_next)
    );

    // Score +1 in BCD, saturating at 99.
    always_comb begin
        score_tens_inc = score_tens;
        score_ones_inc = score_ones;
        if (score_ones != BCD_NINE) begin
            score_ones_inc = score_ones + 4'd1;
        end else if (score_tens != BCD_NINE) begin
            score_tens_inc = score_tens + 4'd1;
            score_ones_inc = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            score_tens <= 4'd0;
            score_ones <= 4'd0;
            ntr_q      <= 1'b0;
            hit_led    <= 1'b0;
            miss_led   <= 1'b0;
        end else begin
            ntr_q <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_p) begin
                        score_tens <= 4'd0;
                        score_ones <= 4'd0;
                        hit_led    <= 1'b0;
                        miss_led   <= 1'b0;
                        ntr_q      <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (tgt.target_valid) begin
                        state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (submit_p) begin
                        if (is_hit) begin
                            hit_led    <= 1'b1;
                            miss_led   <= 1'b0;
                            score_tens <= score_tens_inc;
                            score_ones <= score_ones_inc;
                        end else begin
                            hit_led  <= 1'b0;
                            miss_led <= 1'b1;
                        end
                    end
                    // Running out of time outranks asking for the next target.
                    if (cnt_zero_next) begin
                        state <= ST_OVER;
                    end else if (submit_p && is_hit) begin
                        ntr_q <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_o            = state;
    assign tgt.new_target_req = ntr_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - directed self-checking bench for game_round_ctrl
module tb_game_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       start_key_n = 1'b1;
    logic       submit_key_n = 1'b1;
    logic [7:0] guess = 8'h00;
    logic [3:0] secs_tens, secs_ones, score_tens, score_ones;
    logic [1:0] state_o;
    logic       hit_led, miss_led;

    int vectors = 0;
    int miscompares = 0;

    game_round_ctrl_if #(.GUESS_W(8)) tgt_if ();

    game_round_ctrl #(.GUESS_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1hz     (tick_1hz),
        .start_key_n  (start_key_n),
        .submit_key_n (submit_key_n),
        .guess        (guess),
        .tgt          (tgt_if),
        .secs_tens    (secs_tens),
        .secs_ones    (secs_ones),
        .score_tens   (score_tens),
        .score_ones   (score_ones),
        .state_o      (state_o),
        .hit_led      (hit_led),
        .miss_led     (miss_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
        end
    endtask

    // Press pulse reaches the FSM on the third edge, so results are visible after it.
    task automatic press(input bit is_start);
        if (is_start) start_key_n = 1'b0;
        else          submit_key_n = 1'b0;
        repeat (3) step();
    endtask

    task automatic release_keys();
        start_key_n  = 1'b1;
        submit_key_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic hit();
        guess = 8'hA5;
        press(1'b0);
        release_keys();
    endtask

    initial begin
        tgt_if.target       = 8'hA5;
        tgt_if.target_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_state", state_o, 2'b00);
        check("rst_secs", {secs_tens, secs_ones}, 8'h60);
        check("rst_score", {score_tens, score_ones}, 8'h00);
        check("rst_ntr", tgt_if.new_target_req, 1'b0);
        check("rst_leds", {hit_led, miss_led}, 2'b00);

        // Round 1: start press latency and single pulse
        start_key_n = 1'b0;
        step();
        check("start_e1_ntr", tgt_if.new_target_req, 1'b0);
        step();
        check("start_e2_state", state_o, 2'b00);
        step();
        check("start_e3_ntr", tgt_if.new_target_req, 1'b1);
        check("start_e3_state", state_o, 2'b01);
        step();
        check("start_single_pulse", tgt_if.new_target_req, 1'b0);
        release_keys();

        ticks(1);
        check("load_tick_ignored", {secs_tens, secs_ones}, 8'h60);
        guess = 8'hA5;
        press(1'b0);
        check("load_submit_state", state_o, 2'b01);
        check("load_submit_score", {score_tens, score_ones}, 8'h00);
        check("load_no_reissue", tgt_if.new_target_req, 1'b0);
        release_keys();

        tgt_if.target_valid = 1'b1;
        step();
        check("play_state", state_o, 2'b10);
        check("play_secs", {secs_tens, secs_ones}, 8'h60);
        ticks(1);
        check("tick_59", {secs_tens, secs_ones}, 8'h59);

        guess = 8'hA5;
        press(1'b0);
        check("hit1_led", {hit_led, miss_led}, 2'b10);
        check("hit1_score", {score_tens, score_ones}, 8'h01);
        check("hit1_ntr", tgt_if.new_target_req, 1'b1);
        check("hit1_state", state_o, 2'b01);
        release_keys();
        check("hit1_back_play", state_o, 2'b10);

        repeat (8) hit();
        check("score_09", {score_tens, score_ones}, 8'h09);
        hit();
        check("score_10", {score_tens, score_ones}, 8'h10);
        repeat (89) hit();
        check("score_99", {score_tens, score_ones}, 8'h99);
        hit();
        check("score_sat", {score_tens, score_ones}, 8'h99);
        check("score_sat_led", hit_led, 1'b1);

        press(1'b1);
        check("start_in_play_state", state_o, 2'b10);
        check("start_in_play_ntr", tgt_if.new_target_req, 1'b0);
        release_keys();

        ticks(49);
        check("secs_10", {secs_tens, secs_ones}, 8'h10);
        ticks(1);
        check("secs_09", {secs_tens, secs_ones}, 8'h09);
        ticks(9);
        check("secs_00", {secs_tens, secs_ones}, 8'h00);
        check("over_state", state_o, 2'b11);
        ticks(2);
        check("over_hold_secs", {secs_tens, secs_ones}, 8'h00);
        check("over_hold_score", {score_tens, score_ones}, 8'h99);

        // Round 2: restart from OVER, terminal tick coinciding with a hit
        press(1'b1);
        check("r2_state", state_o, 2'b01);
        check("r2_ntr", tgt_if.new_target_req, 1'b1);
        check("r2_score", {score_tens, score_ones}, 8'h00);
        check("r2_secs", {secs_tens, secs_ones}, 8'h60);
        check("r2_leds", {hit_led, miss_led}, 2'b00);
        release_keys();
        repeat (4) hit();
        ticks(59);
        check("r2_secs_01", {secs_tens, secs_ones}, 8'h01);
        check("r2_score_04", {score_tens, score_ones}, 8'h04);
        guess = 8'hA5;
        submit_key_n = 1'b0;
        step();
        step();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("sim_score", {score_tens, score_ones}, 8'h05);
        check("sim_secs", {secs_tens, secs_ones}, 8'h00);
        check("sim_state", state_o, 2'b11);
        check("sim_no_ntr", tgt_if.new_target_req, 1'b0);
        check("sim_led", {hit_led, miss_led}, 2'b10);
        release_keys();

        // Round 3: miss, then asynchronous reset mid-round
        press(1'b1);
        release_keys();
        repeat (4) hit();
        ticks(23);
        check("r3_secs_37", {secs_tens, secs_ones}, 8'h37);
        guess = 8'h00;
        press(1'b0);
        check("miss_leds", {hit_led, miss_led}, 2'b01);
        check("miss_state", state_o, 2'b10);
        check("miss_score", {score_tens, score_ones}, 8'h04);
`ifdef PENALTY_EN
        check("miss_secs", {secs_tens, secs_ones}, 8'h32);
`else
        check("miss_secs", {secs_tens, secs_ones}, 8'h37);
`endif
        release_keys();

        #2 reset = 1'b1;
        #1;
        check("arst_secs", {secs_tens, secs_ones}, 8'h60);
        check("arst_score", {score_tens, score_ones}, 8'h00);
        check("arst_state", state_o, 2'b00);
        check("arst_leds", {hit_led, miss_led}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_state", state_o, 2'b00);
        check("post_rst_ntr", tgt_if.new_target_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
